// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//
// Multicycle main controller placed directly upstream of instruction decode.
// Each instruction is sequenced through fetch / decode / execute / memory /
// writeback states. All datapath controls are decoded from the current state
// (Moore style). The only exception is FETCH: there, ir_write and pc_write
// also depend on mem_ready, so the instruction register and PC update in the
// same cycle that the memory returns the instruction word.
//
// Ports:
//   clk           system clock; all state updates happen on the rising edge
//   reset         synchronous, active-high
//   opcode[6:0]   instr[6:0] from the instruction register
//   zero          ALU zero flag, used by BEQ
//   mem_ready     memory completes the current access this cycle
//   mem_req       memory access requested
//   mem_write     the current request is a store
//   adr_src       memory address select: 0 = PC, 1 = Result
//   ir_write      latch the instruction register and OldPC
//   pc_write      PC load enable (pc_update | (branch & zero))
//   alu_src_a     00 = PC, 01 = OldPC, 10 = rs1 data
//   alu_src_b     00 = rs2 data, 01 = imm_ext, 10 = constant 4
//   alu_op        00 = add, 01 = sub, 10 = funct-decoded
//   result_src    00 = ALUOut, 01 = read data, 10 = ALU result
//   reg_write     register file write enable
//   illegal_instr sticky flag, set when an unknown opcode is decoded
//   instret       retired-instruction counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH= 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  state_t state;

  // Internal PC-update requests; combined with zero into pc_write.
  logic branch;
  logic pc_update;

  // State register, sticky illegal flag and retire counter. Retirement is
  // counted on the edge that leaves the final state of each instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      illegal_instr <= 1'b0;
      instret       <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ready) state <= DECODE;
        end
        DECODE: begin
          unique case (opcode)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_R:              state <= EXEC_R;
            OP_I:              state <= EXEC_I;
            OP_BRANCH:         state <= BEQ;
            OP_JAL:            state <= JAL;
            default: begin
              state         <= ILLEGAL;
              illegal_instr <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          state <= (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          if (mem_ready) state <= MEMWB;
        end
        MEMWB: begin
          state   <= FETCH;
          instret <= instret + CNT_W'(1);
        end
        MEMWRITE: begin
          if (mem_ready) begin
            state   <= FETCH;
            instret <= instret + CNT_W'(1);
          end
        end
        EXEC_R: state <= ALUWB;
        EXEC_I: state <= ALUWB;
        ALUWB: begin
          state   <= FETCH;
          instret <= instret + CNT_W'(1);
        end
        BEQ: begin
          state   <= FETCH;
          instret <= instret + CNT_W'(1);
        end
        // JAL redirects the PC here, then reuses ALUWB to write PC+4 to rd.
        JAL: state <= ALUWB;
        // Terminal until reset; counter stays frozen.
        ILLEGAL: state <= ILLEGAL;
        default: state <= FETCH;
      endcase
    end
  end

  // Moore output decode. Enables are forced low while reset is high so that
  // a reset landing mid-access never produces a partial write.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    branch     = 1'b0;
    pc_update  = 1'b0;

    unique case (state)
      FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        alu_op     = 2'b00;
        result_src = 2'b10;
        // Capture the instruction and advance PC only when the word arrives.
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        // Precompute the branch target OldPC + imm while decode settles.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
      end
      MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        result_src = 2'b00;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        result_src = 2'b00;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        branch     = 1'b1;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = 2'b00;
        result_src = 2'b00;
        pc_update  = 1'b1;
      end
      ILLEGAL: begin
      end
      default: begin
      end
    endcase

    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign pc_write = (pc_update | (branch & zero)) & ~reset;

endmodule
